// File: rtl/assert_stim_gen_pkg.sv
// Shared types and constants for the constrained 4-bit stimulus generator.
// The checker downstream rejects 4'hF, so every word source must avoid it.
package assert_stim_pkg;

    typedef enum logic [1:0] {
        INCR  = 2'd0,
        WALK  = 2'd1,
        LFSR  = 2'd2,
        CONST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] ILLEGAL_WORD = 4'hF;
    localparam logic [3:0] INCR_MAX     = 4'hE;
    localparam logic [3:0] COVER_WORD   = 4'hA;
    localparam logic [3:0] LFSR_TAPS    = 4'b1100;  // x^4 + x^3 + 1

    // A zero or all-ones seed would either lock up the LFSR or be illegal.
    function automatic logic [3:0] sanitize_seed(input logic [3:0] seed);
        return (seed == 4'h0 || seed == ILLEGAL_WORD) ? 4'h1 : seed;
    endfunction

    function automatic logic [3:0] legalize(input logic [3:0] word);
        return (word == ILLEGAL_WORD) ? 4'h0 : word;
    endfunction

endpackage

// File: rtl/assert_stim_gen_lfsr4.sv
// 4-bit Fibonacci LFSR; exposes both the current and the next state so the
// caller can preload the word that follows a handshake.
module lfsr4
    import assert_stim_pkg::*;
#(
    parameter logic [3:0] SEED = 4'h1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    output logic [3:0] state,
    output logic [3:0] next_state
);

    localparam logic [3:0] SEED_OK = sanitize_seed(SEED);

    assign next_state = {state[2:0], ^(state & LFSR_TAPS)};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_OK;
        end else if (load) begin
            state <= SEED_OK;
        end else if (advance) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/assert_stim_gen.sv
// Stimulus generator: emits a programmed number of legal 4-bit words over a
// valid/ready handshake and flags whether the cover word 4'hA was transferred.
module assert_stim_gen
    import assert_stim_pkg::*;
#(
    parameter logic [3:0] SEED  = 4'h1,
    parameter int         LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] length,
    output logic [3:0]       data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] sent_count,
    output logic             hit_a
);

    localparam logic [3:0] SEED_OK = sanitize_seed(SEED);

    state_e           state, state_nxt;
    mode_e            mode_q;
    logic [LEN_W-1:0] len_q;
    logic [3:0]       first_word, next_word;
    logic [3:0]       lfsr_q, lfsr_nxt;
    logic             handshake, last_xfer, start_go;

    assign handshake = (state == RUN) && data_ready;
    assign last_xfer = handshake && (sent_count == len_q - LEN_W'(1));
    assign start_go  = (state == IDLE) && start && !abort;

    lfsr4 #(.SEED(SEED)) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (1'b0),
        .advance    (handshake && mode_q == LFSR),
        .state      (lfsr_q),
        .next_state (lfsr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: each combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = (length != '0) ? RUN : DONE;
                RUN:     if (last_xfer) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        data_valid = (state == RUN);
        busy       = (state == RUN);
        done       = (state == DONE);
    end

    always_comb begin
        first_word = 4'h0;
        case (mode_e'(mode))
            INCR:  first_word = 4'h0;
            WALK:  first_word = 4'h1;
            LFSR:  first_word = legalize(lfsr_q);
            CONST: first_word = SEED_OK;
            default: first_word = 4'h0;
        endcase
    end

    // The follow-on word is prepared from the current one so it can be shown
    // on the cycle right after its predecessor's handshake.
    always_comb begin
        next_word = data_out;
        case (mode_q)
            INCR:  next_word = (data_out == INCR_MAX) ? 4'h0 : data_out + 4'd1;
            WALK:  next_word = {data_out[2:0], data_out[3]};
            LFSR:  next_word = legalize(lfsr_nxt);
            CONST: next_word = SEED_OK;
            default: next_word = data_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= INCR;
            len_q      <= '0;
            data_out   <= 4'h0;
            sent_count <= '0;
            hit_a      <= 1'b0;
        end else if (start_go) begin
            mode_q     <= mode_e'(mode);
            len_q      <= length;
            data_out   <= first_word;
            sent_count <= '0;
            hit_a      <= 1'b0;
        end else if (handshake) begin
            if (sent_count != {LEN_W{1'b1}}) sent_count <= sent_count + LEN_W'(1);
            if (data_out == COVER_WORD) hit_a <= 1'b1;
            data_out <= next_word;
        end
    end

endmodule

// File: doc/assert_stim_gen.md
# assert_stim_gen

Constrained stimulus generator that drives the 4-bit data stream consumed by the assertion-checking blocks. It emits a programmed number of legal words using a valid/ready handshake, and never emits 4'hF, matching the checker's `data_in < 4'hF` rule. It records coverage-relevant events (value 4'hA transferred) so benches can confirm the checker's cover targets were exercised. It sits between the testbench sequencer and the checker's `data_in` port.

## Interface
Parameters:
- SEED, 4'h1, initial LFSR state and CONST-mode value. A value of 0 or 4'hF is replaced by 4'h1.
- LEN_W, 8, width of the length and transfer counters.

Ports:
- clk  input  1  single clock, all logic on posedge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a sequence; sampled only in IDLE
- abort  input  1  synchronous cancel; highest priority after reset
- mode  input  2  sampled with start: 0 INCR, 1 WALK, 2 LFSR, 3 CONST
- length  input  LEN_W  number of words to send; sampled with start
- data_out  output  4  stimulus word
- data_valid  output  1  data_out is valid
- data_ready  input  1  consumer accepts the word
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at normal completion
- sent_count  output  LEN_W  words transferred in the current or last sequence
- hit_a  output  1  sticky: 4'hA was transferred this sequence

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with length≠0 → RUN. Latch mode and length, clear sent_count and hit_a, load the first word.
  - start=1 with length=0 → DONE. Nothing is transferred.
- RUN:
  - data_valid=1.
  - Handshake is valid && ready. On a handshake: sent_count+1, and set hit_a if the word is 4'hA.
  - The handshake with sent_count+1 == length → DONE. Otherwise load the next word.
- DONE: done=1 for exactly one cycle, then → IDLE.
- abort=1 in any state → IDLE next cycle. data_valid drops, done is not pulsed, and sent_count/hit_a hold.
- start while busy is ignored.
- Word sequences:
  - INCR: 0,1,…,14,0,… Wraps from 14 to 0 and never emits 15.
  - WALK: 1,2,4,8,1,…
  - LFSR: 4-bit Fibonacci with taps x^4+x^3+1, state starting at SEED. It advances once per handshake. An emitted state of 4'hF is output as 4'h0; the LFSR state itself is not altered.
  - CONST: SEED repeated.
- The LFSR state persists across sequences and resets to SEED only on rst_n.
- sent_count saturates at all-ones; it cannot exceed length anyway.

## Timing
- Reset values: data_out=0, data_valid=0, busy=0, done=0, sent_count=0, hit_a=0, FSM=IDLE, LFSR=SEED.
- start sampled at edge t → data_valid=1 with the first word after edge t (latency 1).
- Throughput is one word per cycle while data_ready=1.
- Stall rule: while data_valid && !data_ready, data_out holds stable and data_valid holds high.
- The next word appears the cycle after its handshake. Valid is never dropped between words in RUN.
- Final handshake at edge t → data_valid=0 and done=1 after t; done=0 and IDLE after t+1. A new start is accepted at t+2.
- abort together with a handshake: the transfer counts (sent_count and hit_a update), then the block goes to IDLE.
- rst_n deassertion mid-operation does not apply; assertion of rst_n at any time returns all outputs to reset values immediately (asynchronous).

## Structure
- Package assert_stim_pkg:
  - mode_e enum: INCR, WALK, LFSR, CONST.
  - state_e enum: IDLE, RUN, DONE.
  - Constants ILLEGAL_WORD=4'hF, INCR_MAX=4'hE, COVER_WORD=4'hA, LFSR_TAPS.
- Sub-module lfsr4: 4-bit LFSR with load and advance enables and a sanitized seed. Its reset is the same asynchronous active-low rst_n.
- Top level holds the FSM, word generation mux, counters and hit_a flag.

## Test plan
- Reset, then start mode=INCR, length=20, ready=1 → words 0..14,0..4 on consecutive cycles; done after the 20th; sent_count=20; hit_a=1.
- mode=WALK, length=6, ready toggling 1,0 → words 1,2,4,8,1,2; data_out stable across each stall; done once; sent_count=6.
- mode=LFSR, SEED=1, length=15, ready=1 → 15 words matching the reference LFSR model with 4'hF mapped to 0; no word equals 4'hF.
- start with length=0 → no data_valid; done pulse at the second edge; sent_count=0.
- mode=CONST, length=10, abort asserted after the 3rd handshake → sent_count=3; data_valid low next cycle; no done; a following start is accepted.
- rst_n pulled low mid-RUN with ready=0 → data_valid, busy and sent_count go to 0 immediately; a fresh LFSR sequence restarts from SEED.
